alu_frame_tx: RTL and testbench

Synthesizable, parametrised serial frame transmitter that drives the ALU serial input line `sin`. It takes a whole operation as one transaction (A, B, opcode, error mode), serialises it into data and control frames with a computed CRC4, and can inject protocol errors on request. It replaces the fixed one-op-per-call stimulus driver with a reusable block that test harnesses and future on-chip self-test logic can share.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_crc4.sv | 13 +
 rtl/alu_frame_tx.sv | 115 +++++++++++
 tb/tb_alu_frame_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and frame constants for the ALU serial frame transmitter.
package alu_pkg;
    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        BAD_CRC   = 2'd1,
        DROP_BYTE = 2'd2
    } tx_mode_t;

    localparam int   FRAME_BITS = 11;
    localparam logic TYPE_DATA  = 1'b0;
    localparam logic TYPE_CMD   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CMD,
        S_GAP
    } state_t;
endpackage

// File: rtl/alu_crc4.sv
// alu_crc4: combinational CRC4 (x^4+x+1, init 0) over an MSB-first message.
module alu_crc4 #(
    parameter int MSG_W = 68
) (
    input  logic [MSG_W-1:0] msg,
    output logic [3:0]       crc
);
    always_comb begin
        crc = '0;
        for (int i = MSG_W - 1; i >= 0; i--)
            crc = {crc[2:0], 1'b0} ^ {2'b00, {2{crc[3] ^ msg[i]}}};
    end
endmodule

// File: rtl/alu_frame_tx.sv
// alu_frame_tx: serialises one ALU operation into data frames plus a CRC-protected
// control frame on sin, with optional bad-CRC or dropped-byte error injection.
module alu_frame_tx
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    input  logic [1:0]        mode,
    output logic              sin,
    output logic              busy,
    output logic              done
);
    localparam int N_BYTES = DATA_W / 8;
    localparam int NF      = 2 * N_BYTES;
    localparam int LAST    = FRAME_BITS - 1;

    state_t              state_q, state_d;
    logic [3:0]          bit_q, bit_d;
    logic [7:0]          byte_q, byte_d;
    logic [7:0]          gap_q, gap_d;
    logic [2*DATA_W-1:0] ops_q, ops_d;
    logic [2:0]          op_q, op_d;
    logic [1:0]          mode_q, mode_d;
    logic [3:0]          crc_q, crc_d;
    logic [7:0]          sh_q, sh_d;
    logic [3:0]          crc_w;
    logic [7:0]          last_byte, cur_pay;
    logic                accept, frm;

    alu_crc4 #(.MSG_W(2 * DATA_W + 4)) u_crc (
        .msg({b, a, 1'b1, op}),
        .crc(crc_w)
    );

    always_comb begin
        ready     = state_q == S_IDLE;
        busy      = !ready;
        accept    = valid && ready;
        frm       = state_q == S_DATA || state_q == S_CMD;
        done      = state_q == S_CMD && bit_q == 4'(LAST);
        last_byte = 8'(mode_q == DROP_BYTE ? NF - 2 : NF - 1);
        cur_pay   = state_q == S_CMD ? {1'b0, op_q, mode_q == BAD_CRC ? ~crc_q : crc_q}
                                     : 8'(ops_q >> (8 * (NF - 1 - int'(byte_q))));
        sin       = !frm || (bit_q == 4'd0 ? 1'b0 :
                             bit_q == 4'd1 ? (state_q == S_CMD ? TYPE_CMD : TYPE_DATA) :
                             bit_q == 4'(LAST) ? 1'b1 : sh_q[7]);
        state_d   = state_q;
        bit_d     = frm ? (bit_q == 4'(LAST) ? 4'd0 : bit_q + 4'd1) : 4'd0;
        byte_d    = byte_q;
        gap_d     = gap_q;
        ops_d     = ops_q;
        op_d      = op_q;
        mode_d    = mode_q;
        crc_d     = crc_q;
        // payload byte is latched on the start bit and shifted out MSB first
        sh_d      = bit_q == 4'd0 ? cur_pay : (bit_q >= 4'd2 && bit_q <= 4'd9) ? sh_q << 1 : sh_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_DATA;
                ops_d   = {b, a};
                op_d    = op;
                mode_d  = mode;
                crc_d   = crc_w;
                byte_d  = '0;
            end
            S_DATA: if (bit_q == 4'(LAST)) begin
                if (byte_q == last_byte) begin
                    state_d = S_CMD;
                    byte_d  = '0;
                end else
                    byte_d = byte_q + 8'd1;
            end
            S_CMD: if (bit_q == 4'(LAST)) begin
                state_d = GAP == 0 ? S_IDLE : S_GAP;
                gap_d   = '0;
            end
            default: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == 8'(GAP - 1)) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            ops_q   <= '0;
            op_q    <= '0;
            mode_q  <= '0;
            crc_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            ops_q   <= ops_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            crc_q   <= crc_d;
            sh_q    <= sh_d;
        end
    end
endmodule

// File: tb/tb_alu_frame_tx.sv
// tb_alu_frame_tx: directed vector bench for alu_frame_tx (GAP=4 and GAP=0 instances).
module tb_alu_frame_tx;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic [1:0]  mode = '0;
    logic        valid4 = 1'b0, valid0 = 1'b0;
    logic        ready4, sin4, busy4, done4;
    logic        ready0, sin0, busy0, done0;
    int          checks = 0;
    int          errors = 0;
    logic        exp_bits [0:199];
    int          nf;

    always #5 clk = ~clk;

    alu_frame_tx #(.DATA_W(32), .GAP(4)) u_dut4 (
        .clk(clk), .rst(rst), .valid(valid4), .ready(ready4), .a(a), .b(b),
        .op(op), .mode(mode), .sin(sin4), .busy(busy4), .done(done4)
    );

    alu_frame_tx #(.DATA_W(32), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .valid(valid0), .ready(ready0), .a(a), .b(b),
        .op(op), .mode(mode), .sin(sin0), .busy(busy0), .done(done0)
    );

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [1:0]  mode;
        int          exp_done;
        logic [7:0]  exp_ctrl;
        bit          chk_ctrl;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [3:0] crc_ref(input logic [67:0] m);
        logic [3:0] c = '0;
        logic       fb;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    task automatic build(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                         input logic [1:0] tm);
        logic [63:0] ops = {tb, ta};
        logic [3:0]  c   = crc_ref({tb, ta, 1'b1, top});
        int          nd  = (tm == 2'd2) ? 7 : 8;
        int          k   = 1;
        logic [7:0]  p;
        nf = nd + 1;
        for (int f = 0; f < nf; f++) begin
            p = (f < nd) ? ops[63 - 8 * f -: 8] : {1'b0, top, (tm == 2'd1) ? ~c : c};
            exp_bits[k]     = 1'b0;
            exp_bits[k + 1] = (f == nd);
            for (int j = 0; j < 8; j++) exp_bits[k + 2 + j] = p[7 - j];
            exp_bits[k + 10] = 1'b1;
            k += 11;
        end
    endtask

    // Caller is just past a negedge with the selected DUT ready; ends at the negedge where ready returns.
    task automatic run(input int sel, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] top, input logic [1:0] tm, input string nm,
                       output int got_done, output logic [7:0] got_ctrl);
        int   gap = sel ? 4 : 0;
        int   last, base;
        logic s, d, r, bz;
        build(ta, tb, top, tm);
        last     = 11 * nf;
        base     = 11 * (nf - 1);
        got_done = -1;
        got_ctrl = '0;
        a = ta; b = tb; op = top; mode = tm;
        if (sel != 0) valid4 = 1'b1; else valid0 = 1'b1;
        chk($sformatf("%s.ready_at_accept", nm), sel ? ready4 : ready0, 1);
        @(posedge clk);
        #1;
        valid4 = 1'b0; valid0 = 1'b0;
        a = ~ta; b = tb ^ 32'h5A5A_A5A5; op = ~top; mode = tm ^ 2'd1;
        for (int k = 1; k <= last + gap + 1; k++) begin
            @(negedge clk);
            s  = sel ? sin4 : sin0;
            d  = sel ? done4 : done0;
            r  = sel ? ready4 : ready0;
            bz = sel ? busy4 : busy0;
            chk($sformatf("%s.sin[%0d]", nm, k), s, (k <= last) ? exp_bits[k] : 1'b1);
            chk($sformatf("%s.done[%0d]", nm, k), d, k == last);
            chk($sformatf("%s.ready[%0d]", nm, k), r, k == last + gap + 1);
            chk($sformatf("%s.busy[%0d]", nm, k), bz, k != last + gap + 1);
            if (d && got_done < 0) got_done = k;
            if (k >= base + 3 && k <= base + 10) got_ctrl = {got_ctrl[6:0], s};
        end
    endtask

    initial begin
        int         gd;
        logic [7:0] gc;
        vecs[0] = '{1, 32'h0, 32'h0, 3'd0, 2'd0, 99, 8'h0B, 1'b1};
        vecs[1] = '{1, 32'h0, 32'h0, 3'd0, 2'd1, 99, 8'h04, 1'b1};
        vecs[2] = '{1, 32'hAABBCCDD, 32'h01020304, 3'd5, 2'd2, 88, 8'h00, 1'b0};
        vecs[3] = '{1, 32'h0, 32'h0, 3'd7, 2'd3, 99, 8'h72, 1'b1};
        vecs[4] = '{1, 32'h12345678, 32'h9ABCDEF0, 3'd2, 2'd0, 99, 8'h00, 1'b0};
        vecs[5] = '{0, 32'hFFFFFFFF, 32'h00000000, 3'd6, 2'd0, 99, 8'h00, 1'b0};
        vecs[6] = '{0, 32'hDEADBEEF, 32'hCAFEF00D, 3'd1, 2'd2, 88, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst.sin", sin4, 1);
        chk("rst.ready", ready4, 1);
        chk("rst.busy", busy4, 0);
        chk("rst.done", done4, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle.sin[%0d]", i), sin4, 1);
            chk($sformatf("idle.ready[%0d]", i), ready4, 1);
            chk($sformatf("idle.busy[%0d]", i), busy4, 0);
            chk($sformatf("idle.sin0[%0d]", i), sin0, 1);
        end

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].mode,
                $sformatf("vec%0d", i), gd, gc);
            chk($sformatf("vec%0d.done_cycle", i), gd, vecs[i].exp_done);
            if (vecs[i].chk_ctrl) chk($sformatf("vec%0d.ctrl", i), gc, vecs[i].exp_ctrl);
        end

        a = 32'h11111111; b = 32'h22222222; op = 3'd3; mode = 2'd0;
        valid4 = 1'b1;
        @(posedge clk);
        #1 valid4 = 1'b0;
        repeat (23) @(negedge clk);
        chk("abort.pre_sin", sin4, 0);
        chk("abort.pre_busy", busy4, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort.sin", sin4, 1);
        chk("abort.ready", ready4, 1);
        chk("abort.busy", busy4, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort.ready_after", ready4, 1);
        run(1, 32'h0BADF00D, 32'h76543210, 3'd4, 2'd0, "post_abort", gd, gc);
        chk("post_abort.done_cycle", gd, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
